// File: rtl/regfile_2r1w_pkg.sv
// Shared constants and helpers for the project-2 register file.
// be_merge is used by both the storage write path and the optional write bypass.
package proy2_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_W     = 1024;
    localparam int MAX_BYTES = MAX_W / BYTE_W;

    // Address width for a given depth; a single-word file still needs one address bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Byte-granular merge at the widest supported word; callers cast to and from their width.
    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]     old_w,
        input logic [MAX_W-1:0]     new_w,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_W-1:0] merged;
        merged = old_w;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (be[b]) begin
                merged[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: one write port and two registered read ports.
// master drives requests (datapath side), slave is the register file.
interface regfile_2r1w_if
    import proy2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) ();

    localparam int ADDR_W    = addr_width(DEPTH);
    localparam int NUM_BYTES = WIDTH / BYTE_W;

    logic                 clear;
    logic                 we;
    logic [ADDR_W-1:0]    waddr;
    logic [WIDTH-1:0]     wdata;
    logic [NUM_BYTES-1:0] wbe;

    logic                 re_a;
    logic [ADDR_W-1:0]    raddr_a;
    logic [WIDTH-1:0]     rdata_a;
    logic                 rvalid_a;

    logic                 re_b;
    logic [ADDR_W-1:0]    raddr_b;
    logic [WIDTH-1:0]     rdata_b;
    logic                 rvalid_b;

    modport master (
        output clear, we, waddr, wdata, wbe,
        output re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b
    );

    modport slave (
        input  clear, we, waddr, wdata, wbe,
        input  re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b
    );

endinterface

// File: rtl/regfile_2r1w_word.sv
// One storage word of the register file with byte-enabled writes.
// Priority is rst, then clear, then write.
module regfile_word
    import proy2_pkg::*;
#(
    parameter  int WIDTH     = 32,
    localparam int NUM_BYTES = WIDTH / BYTE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 we,
    input  logic [NUM_BYTES-1:0] wbe,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clear) begin
            r_q <= '0;
        end else if (we) begin
            r_q <= WIDTH'(be_merge(MAX_W'(r_q), MAX_W'(wdata), MAX_BYTES'(wbe)));
        end
    end

    assign q = r_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with byte enables, bulk clear and
// registered reads. Define REGFILE_WRITE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_2r1w
    import proy2_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_2r1w_if.slave    bus
);

    localparam int ADDR_W = addr_width(DEPTH);

    logic [WIDTH-1:0] w_q [DEPTH];
    logic [WIDTH-1:0] w_raw_a;
    logic [WIDTH-1:0] w_raw_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_rvalid_a;
    logic             r_rvalid_b;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign w_q[gi] = '0;
            end else begin : g_store
                regfile_word #(
                    .WIDTH (WIDTH)
                ) u_word (
                    .clk   (clk),
                    .rst   (rst),
                    .clear (bus.clear),
                    .we    (bus.we && ({1'b0, bus.waddr} == (ADDR_W+1)'(gi))),
                    .wbe   (bus.wbe),
                    .wdata (bus.wdata),
                    .q     (w_q[gi])
                );
            end
        end
    endgenerate

    // Compare-based mux: addresses past DEPTH match nothing and read as 0.
    always_comb begin
        w_raw_a = '0;
        w_raw_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, bus.raddr_a} == (ADDR_W+1)'(i)) w_raw_a = w_q[i];
            if ({1'b0, bus.raddr_b} == (ADDR_W+1)'(i)) w_raw_b = w_q[i];
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic             w_wr_live;
    logic [WIDTH-1:0] w_merge_a;
    logic [WIDTH-1:0] w_merge_b;

    // A write only lands if it is in range, writable and not overridden by clear.
    assign w_wr_live = bus.we && !bus.clear
                     && ({1'b0, bus.waddr} < (ADDR_W+1)'(DEPTH))
                     && !(ZERO_REG != 0 && bus.waddr == '0);

    assign w_merge_a = WIDTH'(be_merge(MAX_W'(w_raw_a), MAX_W'(bus.wdata), MAX_BYTES'(bus.wbe)));
    assign w_merge_b = WIDTH'(be_merge(MAX_W'(w_raw_b), MAX_W'(bus.wdata), MAX_BYTES'(bus.wbe)));

    assign w_rd_a = (w_wr_live && bus.raddr_a == bus.waddr) ? w_merge_a : w_raw_a;
    assign w_rd_b = (w_wr_live && bus.raddr_b == bus.waddr) ? w_merge_b : w_raw_b;
`else
    assign w_rd_a = w_raw_a;
    assign w_rd_b = w_raw_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= bus.re_a;
            r_rvalid_b <= bus.re_b;
            if (bus.re_a) r_rdata_a <= w_rd_a;
            if (bus.re_b) r_rdata_b <= w_rd_b;
        end
    end

    assign bus.rdata_a  = r_rdata_a;
    assign bus.rdata_b  = r_rdata_b;
    assign bus.rvalid_a = r_rvalid_a;
    assign bus.rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (WIDTH=32, DEPTH=20, ZERO_REG=1).
// Expected values are hand-computed; bypass-dependent ones follow REGFILE_WRITE_BYPASS_EN.
module tb_regfile_2r1w;

    localparam int WIDTH = 32;
    localparam int DEPTH = 20;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    regfile_2r1w_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_2r1w #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        bus.wbe   = be;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic rd_a(input logic [4:0] addr);
        bus.re_a    = 1'b1;
        bus.raddr_a = addr;
        tick();
        bus.re_a    = 1'b0;
    endtask

    task automatic rd_b(input logic [4:0] addr);
        bus.re_b    = 1'b1;
        bus.raddr_b = addr;
        tick();
        bus.re_b    = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_v;
        n_asserts   = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.clear   = 1'b0;
        bus.we      = 1'b0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.wbe     = '0;
        bus.re_a    = 1'b0;
        bus.raddr_a = '0;
        bus.re_b    = 1'b0;
        bus.raddr_b = '0;

        // Power-up reset
        tick();
        tick();
        rst = 1'b0;
        check("reset rvalid_a", {31'b0, bus.rvalid_a}, 32'h0);
        check("reset rdata_a", bus.rdata_a, 32'h0);
        check("reset rvalid_b", {31'b0, bus.rvalid_b}, 32'h0);
        check("reset rdata_b", bus.rdata_b, 32'h0);

        // Arbitrary writes, then a 2-cycle reset wipes everything
        wr(5'd3, 32'hCAFEF00D, 4'hF);
        wr(5'd10, 32'h13579BDF, 4'hF);
        wr(5'd19, 32'h2468ACE0, 4'hF);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.re_a    = 1'b1;
            bus.raddr_a = 5'(i);
            bus.re_b    = 1'b1;
            bus.raddr_b = 5'(DEPTH - 1 - i);
            tick();
            check("post-reset rdata_a", bus.rdata_a, 32'h0);
            check("post-reset rvalid_a", {31'b0, bus.rvalid_a}, 32'h1);
            check("post-reset rdata_b", bus.rdata_b, 32'h0);
            check("post-reset rvalid_b", {31'b0, bus.rvalid_b}, 32'h1);
        end
        bus.re_a = 1'b0;
        bus.re_b = 1'b0;

        // Byte-enable merge
        wr(5'd5, 32'hDEADBEEF, 4'b1111);
        wr(5'd5, 32'h000000AA, 4'b0001);
        rd_a(5'd5);
        check("be merge rdata_a", bus.rdata_a, 32'hDEADBEAA);
        check("be merge rvalid_a", {31'b0, bus.rvalid_a}, 32'h1);
        tick();
        check("idle rvalid_a", {31'b0, bus.rvalid_a}, 32'h0);
        check("idle rdata_a holds", bus.rdata_a, 32'hDEADBEAA);

        wr(5'd5, 32'hFFFFFFFF, 4'b0000);
        rd_b(5'd5);
        check("wbe=0 no-op", bus.rdata_b, 32'hDEADBEAA);
        wr(5'd5, 32'h12345678, 4'b0110);
        rd_b(5'd5);
        check("be middle bytes", bus.rdata_b, 32'hDE3456AA);

        // Zero register, top word, out-of-range
        wr(5'd0, 32'h12345678, 4'hF);
        rd_b(5'd0);
        check("zero reg rdata_b", bus.rdata_b, 32'h0);
        check("zero reg rvalid_b", {31'b0, bus.rvalid_b}, 32'h1);
        wr(5'd19, 32'h0F0F0F0F, 4'hF);
        rd_a(5'd19);
        check("top word", bus.rdata_a, 32'h0F0F0F0F);
        wr(5'd25, 32'hBADBAD00, 4'hF);
        rd_b(5'd25);
        check("oor read rdata_b", bus.rdata_b, 32'h0);
        check("oor read rvalid_b", {31'b0, bus.rvalid_b}, 32'h1);
        bus.re_a    = 1'b1;
        bus.raddr_a = 5'd19;
        bus.re_b    = 1'b1;
        bus.raddr_b = 5'd19;
        tick();
        bus.re_a = 1'b0;
        bus.re_b = 1'b0;
        check("same addr rdata_a", bus.rdata_a, 32'h0F0F0F0F);
        check("same addr rdata_b", bus.rdata_b, 32'h0F0F0F0F);

        // Same-cycle write and read
        wr(5'd7, 32'h22222222, 4'hF);
        bus.we      = 1'b1;
        bus.waddr   = 5'd7;
        bus.wdata   = 32'h11111111;
        bus.wbe     = 4'hF;
        bus.re_a    = 1'b1;
        bus.raddr_a = 5'd7;
        tick();
        bus.we   = 1'b0;
        bus.re_a = 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_v = 32'h11111111;
`else
        exp_v = 32'h22222222;
`endif
        check("rw same cycle A", bus.rdata_a, exp_v);
        rd_a(5'd7);
        check("rw follow-up A", bus.rdata_a, 32'h11111111);

        bus.we      = 1'b1;
        bus.waddr   = 5'd7;
        bus.wdata   = 32'hAAAA5555;
        bus.wbe     = 4'b0011;
        bus.re_b    = 1'b1;
        bus.raddr_b = 5'd7;
        tick();
        bus.we   = 1'b0;
        bus.re_b = 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_v = 32'h11115555;
`else
        exp_v = 32'h11111111;
`endif
        check("rw partial B", bus.rdata_b, exp_v);
        rd_b(5'd7);
        check("rw partial follow-up B", bus.rdata_b, 32'h11115555);

        bus.we      = 1'b1;
        bus.waddr   = 5'd0;
        bus.wdata   = 32'hFFFFFFFF;
        bus.wbe     = 4'hF;
        bus.re_a    = 1'b1;
        bus.raddr_a = 5'd0;
        tick();
        bus.we   = 1'b0;
        bus.re_a = 1'b0;
        check("rw zero reg", bus.rdata_a, 32'h0);

        // Clear beats a same-cycle write; reads see pre-clear contents
        wr(5'd1, 32'h00000101, 4'hF);
        wr(5'd2, 32'h00000202, 4'hF);
        wr(5'd3, 32'h00000303, 4'hF);
        bus.clear   = 1'b1;
        bus.we      = 1'b1;
        bus.waddr   = 5'd2;
        bus.wdata   = 32'h00000999;
        bus.wbe     = 4'hF;
        bus.re_a    = 1'b1;
        bus.raddr_a = 5'd2;
        bus.re_b    = 1'b1;
        bus.raddr_b = 5'd3;
        tick();
        bus.clear = 1'b0;
        bus.we    = 1'b0;
        bus.re_a  = 1'b0;
        bus.re_b  = 1'b0;
        check("clear cycle read A", bus.rdata_a, 32'h00000202);
        check("clear cycle read B", bus.rdata_b, 32'h00000303);
        rd_a(5'd1);
        check("cleared word 1", bus.rdata_a, 32'h0);
        rd_a(5'd2);
        check("cleared word 2 write lost", bus.rdata_a, 32'h0);
        rd_b(5'd3);
        check("cleared word 3", bus.rdata_b, 32'h0);
        rd_b(5'd5);
        check("cleared word 5", bus.rdata_b, 32'h0);
        rd_a(5'd7);
        check("cleared word 7", bus.rdata_a, 32'h0);

        // Reset right after a read drops valid and data
        wr(5'd4, 32'h44444444, 4'hF);
        rd_a(5'd4);
        check("pre-reset read data", bus.rdata_a, 32'h44444444);
        bus.re_a    = 1'b1;
        bus.raddr_a = 5'd4;
        rst         = 1'b1;
        tick();
        rst      = 1'b0;
        bus.re_a = 1'b0;
        check("mid-read reset rvalid_a", {31'b0, bus.rvalid_a}, 32'h0);
        check("mid-read reset rdata_a", bus.rdata_a, 32'h0);
        tick();
        check("after reset rvalid_a", {31'b0, bus.rvalid_a}, 32'h0);
        check("after reset rdata_a", bus.rdata_a, 32'h0);
        rd_a(5'd4);
        check("word 4 wiped", bus.rdata_a, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised multi-word register file with two read ports and one write port, plus byte-enable writes. It succeeds the fixed 32-bit enabled register and gains synchronous reset, a bulk clear, registered reads with a valid strobe, and an optional hardwired zero register. It sits between the datapath and the ALU operand/result buses of the project-2 processor.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8.
DEPTH, 32, number of words; need not be a power of 2.
ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
ZERO_REG, 1, when 1 word 0 always reads 0 and writes to it are discarded.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
clear  in  1  synchronous bulk clear of all words.
we  in  1  write enable.
waddr  in  ADDR_W  write address.
wdata  in  WIDTH  write data.
wbe  in  WIDTH/8  byte enables; bit i gates wdata[8i+7:8i].
re_a  in  1  read request, port A.
raddr_a  in  ADDR_W  read address, port A.
rdata_a  out  WIDTH  registered read data, port A.
rvalid_a  out  1  rdata_a was updated this cycle.
re_b, raddr_b, rdata_b, rvalid_b  same as port A, for port B.

Behaviour:
- Reset: rst=1 at a rising edge sets all words, rdata_a/b and rvalid_a/b to 0. rst takes priority over clear, we and re. Reset mid-read drops the pending rvalid; no stale data is emitted.
- Write: we=1 at an edge with waddr < DEPTH updates only the bytes whose wbe bit is 1; other bytes hold. we=1 with wbe=0 is a no-op.
- Out-of-range write (waddr >= DEPTH) is ignored. With ZERO_REG=1, a write to address 0 is also ignored.
- Clear: clear=1 (and rst=0) zeroes every word. A write in the same cycle is discarded because clear wins. Reads in that cycle are still serviced with the pre-clear contents.
- Read: 1-cycle latency. If re_x=1 at edge N, then after edge N rdata_x = mem[raddr_x] as it was before edge N, and rvalid_x=1 for exactly that cycle.
- If re_x=0, rvalid_x=0 and rdata_x holds its last value.
- Out-of-range read returns 0 with rvalid_x=1. With ZERO_REG=1, a read of address 0 returns 0.
- Both ports may read the same or different addresses in the same cycle, with no conflict.
- Same-cycle write and read of the same address (no bypass): the read returns the old value.
- No combinational path from any input to any output.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined: when a read and a write hit the same in-range, writable address in the same cycle, rdata_x returns the merged value (bytes enabled by wbe come from wdata, the rest from the old word). Bypass is suppressed when clear=1, and also for address 0 when ZERO_REG=1.
- Undefined: the read returns the old value, as in Behaviour.

Decomposition:
- Package proy2_pkg:
  - BYTE_W=8.
  - Function be_merge(old, new, be) returning the byte-merged word, shared by the write path and the bypass path.
  - Localparam NUM_BYTES=WIDTH/8, computed in-module from the package constant.
- Sub-module regfile_word: one WIDTH-bit storage word with ports clk, rst, clear, we, wbe, wdata, q. It is generated DEPTH times (ZERO_REG skips word 0 and ties it to 0).
- Read muxes and output registers live in regfile_2r1w.

Test Plan:
- rst=1 for 2 cycles after arbitrary writes, then read all addresses on A and B -> every rdata=0, rvalid=1 one cycle after each re.
- Write 0xDEADBEEF to addr 5 with wbe=4'b1111, then write 0x000000AA with wbe=4'b0001, then read A@5 -> 0xDEADBEAA.
- ZERO_REG=1: write 0x12345678 to addr 0, then read B@0 -> 0. Read an address >= DEPTH (e.g. DEPTH=20, addr 25) -> 0, rvalid_b=1.
- Same cycle: we to addr 7 = 0x11111111 (full wbe), re_a@7, with old value 0x22222222 -> rdata_a=0x22222222 without REGFILE_WRITE_BYPASS_EN, 0x11111111 with it. The following read -> 0x11111111 in both builds.
- Fill addrs 1..3, then assert clear together with we to addr 2 -> all words read 0 afterwards, and the write is lost.
- re_a=1 at edge N, rst=1 at edge N+1 -> rvalid_a=0 and rdata_a=0 after N+1; the old data never appears.
